// File: rtl/comparator_pkg.sv
// Shared types for the comparator family: FSM state encoding and the
// three-way compare result carried between blocks.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_result_t;

  localparam cmp_result_t RESULT_CLEAR = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice; the sequential top
// feeds it one digit per cycle.
module cmp_digit
  import comparator_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output cmp_result_t      o_res
);

  always_comb begin
    o_res    = RESULT_CLEAR;
    o_res.gt = (i_a > i_b);
    o_res.lt = (i_a < i_b);
    o_res.eq = (i_a == i_b);
  end

endmodule

// File: rtl/comparator_nbit_seq.sv
// Iterative WIDTH-bit magnitude comparator, signed or unsigned, walking
// DIGIT bits per cycle from the MSB and stopping at the first difference.
module comparator_nbit_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output state_t           dbg_state
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}} >> 0;

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("comparator_nbit_seq: WIDTH must be a positive multiple of DIGIT");
  end

  // Handshake: start is accepted in IDLE or DONE (capturing a, b, signed_mode
  // on that edge) and ignored while busy; busy is high for the COMPARE cycles;
  // done pulses for one cycle and the result outputs are valid from it onwards.
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  cmp_result_t      r_res;
  logic             r_busy;
  logic             r_done;

  logic             w_capture;
  logic             w_latch;
  logic             w_inc;
  logic [WIDTH-1:0] w_sh_a;
  logic [WIDTH-1:0] w_sh_b;
  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  cmp_result_t      w_dig_res;

  // Shifting the current digit up to the MSB end selects it by index.
  always_comb begin
    w_sh_a  = r_a << (int'(r_idx) * DIGIT);
    w_sh_b  = r_b << (int'(r_idx) * DIGIT);
    w_dig_a = w_sh_a[WIDTH-1 -: DIGIT];
    w_dig_b = w_sh_b[WIDTH-1 -: DIGIT];
  end

  cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
    .i_a   (w_dig_a),
    .i_b   (w_dig_b),
    .o_res (w_dig_res)
  );

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_latch   = 1'b0;
    w_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = COMPARE;
        end
      end
      COMPARE: begin
        if (!w_dig_res.eq || (r_idx == LAST_IDX)) begin
          w_latch = 1'b1;
          w_next  = DONE;
        end else begin
          w_inc = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = COMPARE;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_res   <= RESULT_CLEAR;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == COMPARE);
      r_done  <= (w_next == DONE);
      if (w_capture) begin
        // Flipping both sign bits maps two's-complement order onto unsigned order.
        r_a   <= a ^ (signed_mode ? MSB_MASK : '0);
        r_b   <= b ^ (signed_mode ? MSB_MASK : '0);
        r_idx <= '0;
      end else if (w_inc) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_latch) begin
        r_res <= w_dig_res;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign a_gt_b    = r_res.gt;
  assign a_lt_b    = r_res.lt;
  assign a_eq_b    = r_res.eq;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_comparator_nbit_seq.sv
// Bench for comparator_nbit_seq: three instances (DIGIT=4, 1, 16) share the
// stimulus; each has its own expected queue of {done cycle, result}.
module tb_comparator_nbit_seq;
  import comparator_pkg::*;

  localparam int W  = 16;
  localparam int SW = 35;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic [2:0]   exp_res;
    int           lat4;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   busy_v, done_v, gt_v, lt_v, eq_v;
  state_t       st0, st1, st2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  comparator_nbit_seq #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .a_gt_b(gt_v[0]), .a_lt_b(lt_v[0]),
    .a_eq_b(eq_v[0]), .dbg_state(st0));

  comparator_nbit_seq #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .a_gt_b(gt_v[1]), .a_lt_b(lt_v[1]),
    .a_eq_b(eq_v[1]), .dbg_state(st1));

  comparator_nbit_seq #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .a_gt_b(gt_v[2]), .a_lt_b(lt_v[2]),
    .a_eq_b(eq_v[2]), .dbg_state(st2));

  // scoreboard
  logic [SW-1:0] exp_q0[$];
  logic [SW-1:0] exp_q1[$];
  logic [SW-1:0] exp_q2[$];
  int errors = 0;
  int checks = 0;
  int bcnt[3];

  function automatic int dig(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y, input int d);
    logic [W-1:0] df;
    logic [W-1:0] t;
    df = x ^ y;
    for (int i = 0; i < W / d; i++) begin
      t = df << (i * d);
      t = t >> (W - d);
      if (t != '0) return i;
    end
    return (W / d) - 1;
  endfunction

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    logic gt, lt;
    if (m) begin
      gt = ($signed(x) > $signed(y));
      lt = ($signed(x) < $signed(y));
    end else begin
      gt = (x > y);
      lt = (x < y);
    end
    return {gt, lt, (x == y)};
  endfunction

  function automatic int queued();
    return exp_q0.size() + exp_q1.size() + exp_q2.size();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_done(input int i);
    logic [SW-1:0] e;
    int have;
    have = 0;
    e    = '0;
    case (i)
      0: if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1; end
      1: if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1; end
      default: if (exp_q2.size() != 0) begin e = exp_q2.pop_front(); have = 1; end
    endcase
    checks++;
    if (have == 0) begin
      errors++;
      $display("FAIL unexpected_done inst=%0d: got done at cycle %0d, expected none", i, cyc);
    end else begin
      check($sformatf("result_d%0d", dig(i)), {gt_v[i], lt_v[i], eq_v[i]}, e[2:0]);
      check($sformatf("done_cycle_d%0d", dig(i)), cyc, e[SW-1:3]);
      check($sformatf("onehot_d%0d", dig(i)), $countones({gt_v[i], lt_v[i], eq_v[i]}), 1);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) mon_done(i);
    end
  end

  // driver tasks (called at a negedge)
  task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb, input logic m,
                             input logic [2:0] res, input int lat4);
    a           = va;
    b           = vb;
    signed_mode = m;
    start       = 1'b1;
    exp_q0.push_back({32'(cyc + lat4), res});
    exp_q1.push_back({32'(cyc + first_diff(va, vb, 1) + 2), res});
    exp_q2.push_back({32'(cyc + first_diff(va, vb, 16) + 2), res});
  endtask

  task automatic drain();
    int n;
    n    = 0;
    bcnt = '{0, 0, 0};
    do begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) bcnt[i] += int'(busy_v[i]);
      n++;
    end while ((queued() != 0) && (n < 40));
    check("drain_queue_empty", queued(), 0);
  endtask

  task automatic run_one(input logic [W-1:0] va, input logic [W-1:0] vb, input logic m,
                         input logic [2:0] res, input int lat4);
    @(negedge clk);
    drive_start(va, vb, m, res, lat4);
    drain();
    check("busy_cycles_d4", bcnt[0], lat4 - 1);
    check("busy_cycles_d1", bcnt[1], first_diff(va, vb, 1) + 1);
    check("busy_cycles_d16", bcnt[2], 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("hold_d%0d", dig(i)), {gt_v[i], lt_v[i], eq_v[i]}, res);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    logic [W-1:0] ra, rb;
    logic         rm;

    vecs[0] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 2};
    vecs[1] = '{16'h1234, 16'h1234, 1'b0, 3'b001, 5};
    vecs[2] = '{16'h12A4, 16'h12B4, 1'b0, 3'b010, 4};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, 3'b010, 2};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 2};
    vecs[5] = '{16'h1230, 16'h1231, 1'b0, 3'b010, 5};
    vecs[6] = '{16'h8000, 16'h0000, 1'b1, 3'b010, 2};
    vecs[7] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 2};
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, 3'b001, 5};
    vecs[9] = '{16'h1234, 16'h1204, 1'b1, 3'b100, 4};

    // reset held two cycles with start asserted
    rst         = 1'b1;
    start       = 1'b1;
    signed_mode = 1'b0;
    a           = 16'h8000;
    b           = 16'h7FFF;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      check("reset_busy", busy_v, 3'b000);
      check("reset_done", done_v, 3'b000);
      check("reset_results", {gt_v, lt_v, eq_v}, 9'h000);
      check("reset_state_d4", st0, IDLE);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy_v, 3'b000);
    idle(2);

    // table-driven vectors
    for (int v = 0; v < 10; v++)
      run_one(vecs[v].a, vecs[v].b, vecs[v].mode, vecs[v].exp_res, vecs[v].lat4);

    // random vectors, half of them differing in a single random bit
    for (int v = 0; v < 8; v++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = (v % 2 == 0) ? 16'($urandom_range(0, 65535))
                        : (ra ^ (16'h0001 << $urandom_range(0, 15)));
      rm = 1'($urandom_range(0, 1));
      run_one(ra, rb, rm, ref_cmp(ra, rb, rm), first_diff(ra, rb, 4) + 2);
    end

    // start pulsed while busy is ignored
    @(negedge clk);
    drive_start(16'h1234, 16'h1234, 1'b0, 3'b001, 5);
    @(negedge clk);
    a           = 16'hFFFF;
    b           = 16'h0000;
    signed_mode = 1'b1;
    start       = 1'b1;
    drain();
    idle(20);
    for (int i = 0; i < 3; i++)
      check($sformatf("ignored_start_d%0d", dig(i)), {gt_v[i], lt_v[i], eq_v[i]}, 3'b001);

    // start in the DONE cycle: back-to-back compares
    @(negedge clk);
    drive_start(16'h8000, 16'h7FFF, 1'b0, 3'b100, 2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done_cycle", done_v, 3'b111);
    drive_start(16'h1234, 16'h1234, 1'b0, 3'b001, 5);
    drain();
    idle(4);
    check("b2b_final_d4", {gt_v[0], lt_v[0], eq_v[0]}, 3'b001);

    // reset in the second COMPARE cycle aborts the long compares
    @(negedge clk);
    drive_start(16'h1234, 16'h1234, 1'b0, 3'b001, 5);
    void'(exp_q0.pop_back());
    void'(exp_q1.pop_back());
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", busy_v[1:0], 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy_v, 3'b000);
    check("abort_done", done_v, 3'b000);
    check("abort_results", {gt_v, lt_v, eq_v}, 9'h000);
    rst = 1'b0;
    idle(20);
    check("abort_no_done_pending", queued(), 0);
    check("abort_results_still_clear", {gt_v, lt_v, eq_v}, 9'h000);

    // normal operation after abort
    run_one(16'h12A4, 16'h12B4, 1'b0, 3'b010, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
